// File: rtl/keypad_pin_if.sv
// keypad_pin_if
//   Connects the keypad column scanner to the PIN lock controller. The
//   controller reads the raw key here and reports the lock status that feeds
//   the door, LED and 7-segment logic.
//   key_down, key_code : currently held key (0-9 digit, 10 '*', 11 '#')
//   unlocked           : lock open
//   fail_pulse         : one-cycle pulse on a wrong PIN
//   prog_done          : one-cycle pulse when a new PIN is stored
//   locked_out         : high during lockout
//   prog_mode          : high while a new PIN is being entered
//   entry_cnt          : digits currently in the entry buffer
//   entry_digits       : entry buffer, newest digit in the LSB nibble
//   tries_left         : wrong attempts still allowed
interface keypad_pin_if #(
  parameter int PIN_LEN = 4
);
  logic                   key_down;
  logic [3:0]             key_code;
  logic                   unlocked;
  logic                   fail_pulse;
  logic                   prog_done;
  logic                   locked_out;
  logic                   prog_mode;
  logic [2:0]             entry_cnt;
  logic [4*PIN_LEN-1:0]   entry_digits;
  logic [1:0]             tries_left;

  modport master (
    output key_down, key_code,
    input  unlocked, fail_pulse, prog_done, locked_out, prog_mode,
           entry_cnt, entry_digits, tries_left
  );

  modport slave (
    input  key_down, key_code,
    output unlocked, fail_pulse, prog_done, locked_out, prog_mode,
           entry_cnt, entry_digits, tries_left
  );
endinterface

// File: rtl/keypad_pin_ctrl.sv
// keypad_pin_ctrl
//   PIN-entry lock controller. Debounces the held key into single events,
//   collects digits, checks them against the stored PIN, counts wrong
//   attempts, enforces a timed lockout and lets the PIN be reprogrammed
//   while the lock is open.
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : keypad_pin_if slave side (key inputs, lock status outputs)
module keypad_pin_ctrl #(
  parameter int                   PIN_LEN         = 4,
  parameter int                   DEBOUNCE_CYCLES = 12500,
  parameter int                   MAX_TRIES       = 3,
  parameter int                   UNLOCK_CYCLES   = 25000000,
  parameter int                   LOCK_CYCLES     = 50000000,
  parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN     = 16'h1234
) (
  input  logic         clk,
  input  logic         rst,
  keypad_pin_if.slave  bus
);

  localparam int          DW        = 4 * PIN_LEN;
  localparam logic [26:0] DEB       = 27'(DEBOUNCE_CYCLES);
  localparam logic [26:0] UNL_LOAD  = 27'(UNLOCK_CYCLES - 1);
  localparam logic [26:0] LOCK_LOAD = 27'(LOCK_CYCLES - 1);
  localparam logic [2:0]  LEN       = 3'(PIN_LEN);
  localparam logic [1:0]  TRIES_MAX = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_PROG     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  // ---------------- debounce ----------------
  logic [3:0]  prev_code_r;
  logic [26:0] stab_r, stab_s;
  logic [26:0] rel_r, rel_s;
  logic        armed_r;
  logic        key_evt_s;

  // Run lengths of the current hold and of the current release; the event
  // fires only on the cycle the hold run first reaches the threshold.
  always_comb begin
    stab_s = 27'd0;
    rel_s  = 27'd0;
    if (bus.key_down) begin
      if (bus.key_code != prev_code_r) begin
        stab_s = 27'd1;
      end else if (stab_r >= DEB) begin
        stab_s = stab_r;
      end else begin
        stab_s = stab_r + 27'd1;
      end
    end else begin
      if (rel_r >= DEB) begin
        rel_s = rel_r;
      end else begin
        rel_s = rel_r + 27'd1;
      end
    end
    key_evt_s = armed_r && bus.key_down && (bus.key_code < 4'd12) &&
                (stab_s == DEB) && (stab_r != DEB);
  end

  // Debounce registers; an event disarms until a long enough release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_code_r <= 4'd0;
      stab_r      <= 27'd0;
      rel_r       <= 27'd0;
      armed_r     <= 1'b1;
    end else begin
      prev_code_r <= bus.key_code;
      stab_r      <= stab_s;
      rel_r       <= rel_s;
      if (key_evt_s) begin
        armed_r <= 1'b0;
      end else if (!bus.key_down && (rel_s == DEB)) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // ---------------- sequencer ----------------
  state_t          state_r, state_s;
  logic [DW-1:0]   buf_r, buf_s;
  logic [2:0]      cnt_r, cnt_s;
  logic [DW-1:0]   pin_r, pin_s;
  logic [1:0]      tries_r, tries_s;
  logic [26:0]     timer_r, timer_s;
  logic            fail_s, done_s;
  logic            unlocked_r, fail_r, done_r, locked_r, prog_r;
  logic            is_digit_s, is_star_s, is_hash_s, full_s;
  logic [DW-1:0]   shifted_s;

  // Next-state and datapath; timer expiry takes priority over key events.
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    cnt_s      = cnt_r;
    pin_s      = pin_r;
    tries_s    = tries_r;
    timer_s    = timer_r;
    fail_s     = 1'b0;
    done_s     = 1'b0;
    is_digit_s = bus.key_code < 4'd10;
    is_star_s  = bus.key_code == 4'd10;
    is_hash_s  = bus.key_code == 4'd11;
    full_s     = cnt_r == LEN;
    shifted_s  = (buf_r << 3'd4) | DW'(bus.key_code);
    case (state_r)
      ST_ENTRY: begin
        if (key_evt_s) begin
          if (is_digit_s) begin
            if (!full_s) begin
              buf_s = shifted_s;
              cnt_s = cnt_r + 3'd1;
            end else begin
              buf_s = buf_r;
            end
          end else if (is_star_s) begin
            buf_s = {DW{1'b0}};
            cnt_s = 3'd0;
          end else if (is_hash_s && full_s) begin
            state_s = ST_CHECK;
          end else begin
            buf_s = {DW{1'b0}};
            cnt_s = 3'd0;
          end
        end else begin
          state_s = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        buf_s = {DW{1'b0}};
        cnt_s = 3'd0;
        if (buf_r == pin_r) begin
          state_s = ST_UNLOCKED;
          tries_s = TRIES_MAX;
          timer_s = UNL_LOAD;
        end else begin
          fail_s  = 1'b1;
          tries_s = tries_r - 2'd1;
          if (tries_r == 2'd1) begin
            state_s = ST_LOCKOUT;
            timer_s = LOCK_LOAD;
          end else begin
            state_s = ST_ENTRY;
          end
        end
      end
      ST_UNLOCKED: begin
        if (timer_r == 27'd0) begin
          state_s = ST_ENTRY;
        end else if (key_evt_s && is_star_s) begin
          state_s = ST_ENTRY;
        end else if (key_evt_s && is_hash_s) begin
          state_s = ST_PROG;
          timer_s = UNL_LOAD;
        end else begin
          timer_s = timer_r - 27'd1;
        end
      end
      ST_PROG: begin
        if (timer_r == 27'd0) begin
          state_s = ST_ENTRY;
          buf_s   = {DW{1'b0}};
          cnt_s   = 3'd0;
        end else if (key_evt_s) begin
          timer_s = UNL_LOAD;
          if (is_digit_s) begin
            if (!full_s) begin
              buf_s = shifted_s;
              cnt_s = cnt_r + 3'd1;
            end else begin
              buf_s = buf_r;
            end
          end else if (is_star_s) begin
            // '*' on an empty buffer leaves programming altogether
            buf_s = {DW{1'b0}};
            cnt_s = 3'd0;
            if (cnt_r == 3'd0) begin
              state_s = ST_ENTRY;
            end else begin
              state_s = ST_PROG;
            end
          end else if (is_hash_s && full_s) begin
            pin_s   = buf_r;
            done_s  = 1'b1;
            buf_s   = {DW{1'b0}};
            cnt_s   = 3'd0;
            state_s = ST_ENTRY;
          end else begin
            buf_s = {DW{1'b0}};
            cnt_s = 3'd0;
          end
        end else begin
          timer_s = timer_r - 27'd1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_r == 27'd0) begin
          state_s = ST_ENTRY;
          tries_s = TRIES_MAX;
        end else begin
          timer_s = timer_r - 27'd1;
        end
      end
      default: begin
        state_s = ST_ENTRY;
      end
    endcase
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_ENTRY;
      buf_r      <= {DW{1'b0}};
      cnt_r      <= 3'd0;
      pin_r      <= DEFAULT_PIN;
      tries_r    <= TRIES_MAX;
      timer_r    <= 27'd0;
      unlocked_r <= 1'b0;
      fail_r     <= 1'b0;
      done_r     <= 1'b0;
      locked_r   <= 1'b0;
      prog_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      buf_r      <= buf_s;
      cnt_r      <= cnt_s;
      pin_r      <= pin_s;
      tries_r    <= tries_s;
      timer_r    <= timer_s;
      unlocked_r <= state_s == ST_UNLOCKED;
      fail_r     <= fail_s;
      done_r     <= done_s;
      locked_r   <= state_s == ST_LOCKOUT;
      prog_r     <= state_s == ST_PROG;
    end
  end

  assign bus.unlocked     = unlocked_r;
  assign bus.fail_pulse   = fail_r;
  assign bus.prog_done    = done_r;
  assign bus.locked_out   = locked_r;
  assign bus.prog_mode    = prog_r;
  assign bus.entry_cnt    = cnt_r;
  assign bus.entry_digits = buf_r;
  assign bus.tries_left   = tries_r;

endmodule

// File: doc/keypad_pin_ctrl.md
Name: keypad_pin_ctrl

Overview:
Sequencer that sits behind the 4x3 keypad column scanner and turns its raw key code into a PIN-entry lock controller. It debounces key presses into single events and collects digits into an entry buffer. It compares the buffer against a stored PIN, manages retry counting and timed lockout, and supports reprogramming the PIN while unlocked. Its outputs drive the door/LED/7-segment logic of the top level.

Parameters:
PIN_LEN, 4, number of digits in a PIN (1..7)
DEBOUNCE_CYCLES, 12500, clk cycles a key must be stable before it is accepted (>=2)
MAX_TRIES, 3, wrong attempts allowed before lockout (1..3)
UNLOCK_CYCLES, 25000000, cycles unlocked stays high, and the PROG inactivity timeout
LOCK_CYCLES, 50000000, lockout duration in cycles
DEFAULT_PIN, 16'h1234, stored PIN after reset; 4 bits per digit, first digit in the MSB nibble

Ports:
clk  in  1  system clock
rst  in  1  reset
key_down  in  1  level; a key is currently held
key_code  in  4  0-9 digit, 10 = '*', 11 = '#'; meaningful only while key_down
unlocked  out  1  lock open
fail_pulse  out  1  one-cycle pulse on a wrong PIN
prog_done  out  1  one-cycle pulse when a new PIN is stored
locked_out  out  1  high during lockout
prog_mode  out  1  high in PROG
entry_cnt  out  3  digits currently in the buffer
entry_digits  out  4*PIN_LEN  entry buffer; newest digit in the LSB nibble
tries_left  out  2  remaining attempts

Behaviour:
- Reset: rst is asynchronous, active-high. State ENTRY; stored PIN = DEFAULT_PIN; tries_left = MAX_TRIES; buffer = 0; entry_cnt = 0; all other outputs 0; debounce and timers cleared.
- Debounce:
  - Stability counter increments while key_down = 1 and key_code equals its previous-cycle value; any change restarts it.
  - When the counter reaches DEBOUNCE_CYCLES, key_evt fires for exactly one cycle (the accept cycle).
  - No further event until key_down has been low for DEBOUNCE_CYCLES consecutive cycles (re-arm).
  - key_code 12-15 never produces an event.
- State updates on the edge after the accept cycle. Events arriving in CHECK or LOCKOUT are dropped.
- ENTRY:
  - Digit: if entry_cnt < PIN_LEN, shift the buffer left one nibble, insert the digit, increment entry_cnt; otherwise ignore.
  - '*': clear buffer and entry_cnt.
  - '#' with entry_cnt == PIN_LEN: go to CHECK.
  - '#' with fewer digits: clear buffer; no try consumed.
- CHECK (exactly one cycle): compare buffer against the stored PIN; clear buffer and entry_cnt.
  - Match: go to UNLOCKED, unlocked = 1, tries_left = MAX_TRIES, timer = UNLOCK_CYCLES-1.
  - Mismatch: fail_pulse = 1 for that transition cycle, decrement tries_left.
  - Mismatch with tries_left now 0: go to LOCKOUT, locked_out = 1, timer = LOCK_CYCLES-1.
  - Mismatch otherwise: return to ENTRY.
- UNLOCKED:
  - Timer decrements each cycle; at 0, go to ENTRY and unlocked = 0.
  - '*': relock to ENTRY immediately.
  - '#': go to PROG; unlocked = 0, prog_mode = 1, timer = UNLOCK_CYCLES-1.
  - Digits are ignored.
- PROG:
  - Digits, '*' and short '#' handled as in ENTRY, except that '*' on an empty buffer aborts to ENTRY.
  - Every accepted event reloads the timer.
  - '#' with a full buffer: stored PIN <= buffer, prog_done pulses for 1 cycle, buffer cleared, go to ENTRY.
  - Timer reaching 0: go to ENTRY, stored PIN unchanged, buffer cleared.
- LOCKOUT: all keys ignored; at timer 0, go to ENTRY, locked_out = 0, tries_left = MAX_TRIES.
- Simultaneous events:
  - A timer expiry and an accepted event on the same edge: the expiry wins and the event is dropped.
  - rst during any state (including mid-PROG) restores DEFAULT_PIN.
- Timers are 27 bits wide; parameter values up to 2^27-1 are legal.

Test Plan:
1. Bench params DEBOUNCE=4, UNLOCK=40, LOCK=60. Press 1,2,3,4,'#', each held 6 cycles with 6 cycles released -> unlocked rises 2 edges after the '#' accept cycle, stays 40 cycles, then falls; tries_left = 3.
2. Key held 3 cycles, or key_code toggling 5->6 while held -> no event, entry_cnt stays 0. A 20-cycle hold -> exactly one event.
3. Enter 1,2,3,5,'#' three times -> three fail_pulses, tries_left 2,1,0; locked_out = 1 for 60 cycles; digits pressed during lockout are ignored; afterwards tries_left = 3.
4. Enter 1,2,3 then '#' -> buffer cleared, tries_left unchanged. Enter 1,2,3,4,5 -> entry_cnt = 4, entry_digits = 16'h1234.
5. Unlock, press '#', then 9,8,7,6,'#' -> prog_done pulses; 1234'#' now fails and 9876'#' unlocks. Assert rst -> 1234 works again.
6. Unlock, then '*' -> unlocked falls on the next edge. In PROG, idle 40 cycles -> return to ENTRY with the PIN unchanged.
